// File: rtl/var_assign_table.sv
// Variable-assignment store for the BCP engine: per-variable value and decision
// level, with write-conflict detection, a live assigned count and a backtrack sweep.
module var_assign_table #(
    parameter int VAR_NUM     = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int LEVEL_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   r_w,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [1:0]             din_val,
    input  logic [LEVEL_WIDTH-1:0] din_level,
    output logic [1:0]             dout_val,
    output logic [LEVEL_WIDTH-1:0] dout_level,
    output logic                   conflict,
    input  logic                   bt_start,
    input  logic [LEVEL_WIDTH-1:0] bt_level,
    output logic                   busy,
    output logic [ADDR_WIDTH:0]    assigned_count
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    localparam logic [1:0]            VAL_NONE  = 2'b00;
    localparam logic [1:0]            VAL_ILL   = 2'b11;
    localparam logic [ADDR_WIDTH:0]   VAR_NUM_W = (ADDR_WIDTH+1)'(VAR_NUM);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(VAR_NUM - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [LEVEL_WIDTH-1:0]   bt_lvl_q, bt_lvl_d;
    logic [1:0]               val_q [VAR_NUM];
    logic [LEVEL_WIDTH-1:0]   lvl_q [VAR_NUM];
    logic [ADDR_WIDTH:0]      count_q, count_d;
    logic [1:0]               dout_val_q, dout_val_d;
    logic [LEVEL_WIDTH-1:0]   dout_level_q, dout_level_d;
    logic                     conflict_q, conflict_d;
    logic                     busy_q, busy_d;

    logic                     addr_ok_s;
    logic [1:0]               cur_val_s;
    logic [LEVEL_WIDTH-1:0]   cur_lvl_s;
    logic [1:0]               sw_val_s;
    logic [LEVEL_WIDTH-1:0]   sw_lvl_s;
    logic                     upd_s;
    logic [ADDR_WIDTH-1:0]    upd_idx_s;
    logic [1:0]               upd_val_s;
    logic [LEVEL_WIDTH-1:0]   upd_lvl_s;

    function automatic logic is_assigned(input logic [1:0] v);
        return (v != VAL_NONE);
    endfunction

    // Current entry at the access address; out-of-range addresses read as empty.
    always_comb begin
        addr_ok_s = ({1'b0, address} < VAR_NUM_W);
        if (addr_ok_s) begin
            cur_val_s = val_q[address];
            cur_lvl_s = lvl_q[address];
        end else begin
            cur_val_s = VAL_NONE;
            cur_lvl_s = '0;
        end
        sw_val_s = val_q[idx_q];
        sw_lvl_s = lvl_q[idx_q];
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bt_start) state_d = S_SWEEP;
                else          state_d = S_IDLE;
            end
            S_SWEEP: begin
                if (idx_q == LAST_IDX) state_d = S_IDLE;
                else                   state_d = S_SWEEP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: access decode, conflict detection, sweep clearing and count update.
    always_comb begin
        idx_d        = idx_q;
        bt_lvl_d     = bt_lvl_q;
        count_d      = count_q;
        dout_val_d   = dout_val_q;
        dout_level_d = dout_level_q;
        conflict_d   = 1'b0;
        upd_s        = 1'b0;
        upd_idx_s    = address;
        upd_val_s    = VAL_NONE;
        upd_lvl_s    = '0;
        case (state_q)
            S_IDLE: begin
                if (bt_start) begin
                    // A start request takes priority; any same-cycle access is dropped.
                    idx_d    = '0;
                    bt_lvl_d = bt_level;
                end else if (en && r_w) begin
                    dout_val_d   = cur_val_s;
                    dout_level_d = cur_lvl_s;
                end else if (en && (din_val != VAL_ILL) && addr_ok_s) begin
                    if (din_val == VAL_NONE) begin
                        upd_s = 1'b1;
                        if (is_assigned(cur_val_s)) count_d = count_q - CNT_ONE;
                        else                        count_d = count_q;
                    end else if (!is_assigned(cur_val_s)) begin
                        upd_s     = 1'b1;
                        upd_val_s = din_val;
                        upd_lvl_s = din_level;
                        count_d   = count_q + CNT_ONE;
                    end else if (cur_val_s != din_val) begin
                        conflict_d = 1'b1;
                    end else begin
                        // Re-asserting the same value keeps the original level.
                        upd_s = 1'b0;
                    end
                end else begin
                    upd_s = 1'b0;
                end
            end
            S_SWEEP: begin
                idx_d     = idx_q + ADDR_WIDTH'(1);
                upd_idx_s = idx_q;
                if (is_assigned(sw_val_s) && (sw_lvl_s > bt_lvl_q)) begin
                    upd_s   = 1'b1;
                    count_d = count_q - CNT_ONE;
                end else begin
                    upd_s = 1'b0;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
        busy_d = (state_d == S_SWEEP);
    end

    // Entry storage; reset clears every variable.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < VAR_NUM; i++) begin
                val_q[i] <= VAL_NONE;
                lvl_q[i] <= '0;
            end
        end else if (upd_s) begin
            val_q[upd_idx_s] <= upd_val_s;
            lvl_q[upd_idx_s] <= upd_lvl_s;
        end else begin
            val_q[upd_idx_s] <= val_q[upd_idx_s];
            lvl_q[upd_idx_s] <= lvl_q[upd_idx_s];
        end
    end

    // Registered outputs and sweep bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q        <= '0;
            bt_lvl_q     <= '0;
            count_q      <= '0;
            dout_val_q   <= VAL_NONE;
            dout_level_q <= '0;
            conflict_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            bt_lvl_q     <= bt_lvl_d;
            count_q      <= count_d;
            dout_val_q   <= dout_val_d;
            dout_level_q <= dout_level_d;
            conflict_q   <= conflict_d;
            busy_q       <= busy_d;
        end
    end

    assign dout_val       = dout_val_q;
    assign dout_level     = dout_level_q;
    assign conflict       = conflict_q;
    assign busy           = busy_q;
    assign assigned_count = count_q;

endmodule

// File: tb/tb_var_assign_table.sv
// Directed self-checking bench for var_assign_table with hand-computed expectations.
module tb_var_assign_table;

    logic       clock = 1'b0;
    logic       reset, en, r_w, bt_start, conflict, busy;
    logic [2:0] address;
    logic [1:0] din_val, dout_val;
    logic [3:0] din_level, dout_level, bt_level;
    logic [3:0] assigned_count;

    int tests_run = 0;
    int tests_failed = 0;

    var_assign_table #(.VAR_NUM(8), .ADDR_WIDTH(3), .LEVEL_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .en(en), .r_w(r_w), .address(address),
        .din_val(din_val), .din_level(din_level), .dout_val(dout_val),
        .dout_level(dout_level), .conflict(conflict), .bt_start(bt_start),
        .bt_level(bt_level), .busy(busy), .assigned_count(assigned_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [1:0] v, input logic [3:0] l,
                            input logic exp_conf);
        en = 1'b1; r_w = 1'b0; address = a; din_val = v; din_level = l;
        tick();
        en = 1'b0;
        check_eq("conflict_after_write", conflict, exp_conf);
        tick();
        check_eq("conflict_next_cycle", conflict, 1'b0);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [1:0] ev, input logic [3:0] el);
        en = 1'b1; r_w = 1'b1; address = a;
        tick();
        en = 1'b0;
        check_eq($sformatf("rd_val[%0d]", a), dout_val, ev);
        check_eq($sformatf("rd_lvl[%0d]", a), dout_level, el);
    endtask

    // Count busy-high samples until the sweep finishes (bounded).
    task automatic wait_sweep(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cycles++;
            tick();
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; en = 1'b0; r_w = 1'b1; address = '0; din_val = '0;
        din_level = '0; bt_start = 1'b0; bt_level = '0;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_count", assigned_count, 4'd0);
        check_eq("rst_conflict", conflict, 1'b0);
        check_eq("rst_dout_val", dout_val, 2'b00);
        for (int a = 0; a < 8; a++) do_read(3'(a), 2'b00, 4'd0);

        do_write(3'd0, 2'b10, 4'd1, 1'b0);
        do_write(3'd1, 2'b01, 4'd2, 1'b0);
        do_write(3'd2, 2'b10, 4'd3, 1'b0);
        do_read(3'd0, 2'b10, 4'd1);
        do_read(3'd1, 2'b01, 4'd2);
        do_read(3'd2, 2'b10, 4'd3);
        check_eq("count_3", assigned_count, 4'd3);

        do_write(3'd1, 2'b10, 4'd5, 1'b1);
        do_read(3'd1, 2'b01, 4'd2);
        do_write(3'd1, 2'b01, 4'd7, 1'b0);
        do_read(3'd1, 2'b01, 4'd2);
        do_write(3'd3, 2'b11, 4'd4, 1'b0);
        do_read(3'd3, 2'b00, 4'd0);
        check_eq("count_after_dup", assigned_count, 4'd3);

        do_write(3'd5, 2'b01, 4'd0, 1'b0);
        check_eq("count_4", assigned_count, 4'd4);

        // Backtrack to level 1.
        bt_level = 4'd1; bt_start = 1'b1;
        tick();
        bt_start = 1'b0;
        wait_sweep(n);
        check_eq("bt1_busy_cycles", n, 8);
        check_eq("bt1_count", assigned_count, 4'd2);
        do_read(3'd0, 2'b10, 4'd1);
        do_read(3'd1, 2'b00, 4'd0);
        do_read(3'd2, 2'b00, 4'd0);
        do_read(3'd5, 2'b01, 4'd0);

        // Access and second start during a sweep are ignored.
        bt_level = 4'd1; bt_start = 1'b1;
        tick();
        bt_start = 1'b0;
        tick();
        en = 1'b1; r_w = 1'b0; address = 3'd6; din_val = 2'b10; din_level = 4'd1;
        bt_start = 1'b1;
        tick();
        en = 1'b0; bt_start = 1'b0;
        wait_sweep(n);
        check_eq("bt2_busy_cycles", n, 6);
        tick();
        check_eq("bt2_no_restart", busy, 1'b0);
        do_read(3'd6, 2'b00, 4'd0);
        check_eq("bt2_count", assigned_count, 4'd2);

        // Same-cycle start and write: the write is dropped.
        bt_level = 4'd15; bt_start = 1'b1;
        en = 1'b1; r_w = 1'b0; address = 3'd7; din_val = 2'b01; din_level = 4'd0;
        tick();
        bt_start = 1'b0; en = 1'b0;
        check_eq("bt3_busy_rise", busy, 1'b1);
        wait_sweep(n);
        check_eq("bt3_busy_cycles", n, 8);
        do_read(3'd7, 2'b00, 4'd0);
        check_eq("bt3_count", assigned_count, 4'd2);

        // Explicit unassign decrements the count.
        do_write(3'd5, 2'b00, 4'd0, 1'b0);
        check_eq("unassign_count", assigned_count, 4'd1);
        do_read(3'd5, 2'b00, 4'd0);

        // Reset in the middle of a sweep.
        do_write(3'd4, 2'b10, 4'd9, 1'b0);
        bt_level = 4'd0; bt_start = 1'b1;
        tick();
        bt_start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_count", assigned_count, 4'd0);
        for (int a = 0; a < 8; a++) do_read(3'(a), 2'b00, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/var_assign_table.md
# var_assign_table

Parametrised variable-assignment store for the hardware BCP engine. It holds a 2-bit value (unassigned/false/true) and a decision level for each of VAR_NUM variables. Single-port register-style read and write, with the same access style as the existing variable table. It adds conflict detection on writes, a live count of assigned variables, and a multi-cycle backtrack sweep that unassigns every variable above a given decision level.

## Interface
- VAR_NUM, 8: number of variables (entries).
- ADDR_WIDTH, 3: address width; 2^ADDR_WIDTH >= VAR_NUM.
- LEVEL_WIDTH, 4: decision-level width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  access enable.
- r_w  in  1  1 = read, 0 = write.
- address  in  ADDR_WIDTH  variable index.
- din_val  in  2  00 = unassigned, 01 = false, 10 = true, 11 = illegal.
- din_level  in  LEVEL_WIDTH  decision level stored with an assignment.
- dout_val  out  2  registered read value.
- dout_level  out  LEVEL_WIDTH  registered read level.
- conflict  out  1  one-cycle pulse: a write opposed an existing assignment.
- bt_start  in  1  start backtrack (sampled in IDLE only).
- bt_level  in  LEVEL_WIDTH  backtrack target level.
- busy  out  1  high while the backtrack sweep runs.
- assigned_count  out  ADDR_WIDTH+1  number of entries with val != 00.

## Operation
- Reset:
  - All entries become val = 00, level = 0.
  - dout_val = 0, dout_level = 0, conflict = 0, busy = 0, assigned_count = 0.
  - FSM goes to IDLE.
  - Reset wins over every other input, including mid-sweep.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on bt_start. Capture bt_level and clear the sweep index.
  - SWEEP -> IDLE after processing index VAR_NUM-1.
- Read (IDLE, en=1, r_w=1, no bt_start):
  - dout_val/dout_level load entry[address].
  - For address >= VAR_NUM, they load 0.
  - When no read occurs, dout holds its value.
- Write (IDLE, en=1, r_w=0, no bt_start), checked against the current entry value cur:
  - din_val=11, or address >= VAR_NUM: no change.
  - din_val=00: entry is set to val 00, level 0. Count decrements if cur != 00.
  - cur=00, din_val in {01,10}: store val and level. Count increments.
  - cur == din_val: no change; the level is NOT overwritten.
  - cur and din_val opposite (01 vs 10): no change. conflict = 1 for one cycle.
- conflict is 0 in every cycle not described above.
- Backtrack (SWEEP):
  - Process one entry per cycle, index 0..VAR_NUM-1.
  - If val != 00 and level > captured bt_level, clear the entry to 00/0 and decrement the count.
  - The comparison is unsigned.
  - bt_level = 0 clears all assignments at level >= 1. Level-0 assignments survive.
- Simultaneous events:
  - bt_start and en asserted together in IDLE: backtrack starts and the access is dropped.
  - en and bt_start during SWEEP are ignored; dout holds.
- assigned_count is never below 0 or above VAR_NUM.

## Timing
- Read latency is 1 cycle: address is sampled at edge N and dout is valid after edge N.
- Write takes effect at edge N. A read of the same address issued at edge N+1 returns the new value.
- conflict is asserted for the cycle after the offending write edge.
- busy:
  - Rises on the edge that samples bt_start.
  - Stays high for exactly VAR_NUM cycles.
  - Falls on the edge that processes index VAR_NUM-1.
- The first access is accepted on the edge where busy is already 0.
- assigned_count updates on the same edge as the entry change.

## Test plan
- Reset, then read addresses 0..7: every read returns dout_val=00, dout_level=0; assigned_count=0; busy=0.
- Write addr0=10/L1, addr1=01/L2, addr2=10/L3, then read each:
  - Reads return 10/1, 01/2, 10/3.
  - assigned_count=3; conflict stays 0.
- Conflict and duplicate handling:
  - Write addr1=10/L5: conflict pulses for exactly 1 cycle; addr1 still reads 01/2.
  - Write addr1=01/L7: no conflict; addr1 still reads 01/2.
  - Write din_val=11 to addr3: addr3 still reads 00; count unchanged.
- Backtrack with the three assignments above plus addr5=01/L0 (count=4), bt_level=1:
  - busy is high for 8 cycles.
  - Afterwards addr0=10/1 and addr5=01/0 remain; addr1 and addr2 read 00.
  - assigned_count=2.
- During a sweep, issue write addr6=10/L1 and a second bt_start:
  - Both are ignored; addr6 reads 00 after the sweep.
  - Same-cycle bt_start with a write in IDLE: the write is dropped.
- Assert reset at sweep cycle 3: next cycle busy=0, assigned_count=0, and all entries read 00/0.
